// File: rtl/imem_uart_loader_pkg.sv
// Shared constants and encodings for the UART instruction-memory boot loader.
package imem_uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT_SYNC, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERR
  } ld_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module imem_uart_loader_uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     st_q, st_d;
  logic          meta_q, sync_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          bv_q, bv_d, fe_q, fe_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    case (st_q)
      RX_IDLE:
        if (prev_q && !sync_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      // A glitch shorter than half a bit falls back to idle here.
      RX_START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + 1'b1;
      RX_DATA:
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      RX_STOP:
        if (cnt_q == FULL) begin
          st_d = RX_IDLE;
          if (sync_q) begin
            data_d = shift_q;
            bv_d   = 1'b1;
          end else fe_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign data       = data_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Framed serial boot loader: writes a checksummed image into i_ram, holds the CPU until verified.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_HZ      = 16_000_000,
  parameter int BAUD        = 1_000_000,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] w_addr,
  output logic [15:0]       din,
  output logic              w_en,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  logic [7:0] rd;
  logic       bv, fe;

  imem_uart_loader_uart_rx #(.CLKS_PER_BIT(clks_per_bit(CLK_HZ, BAUD))) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .data(rd), .byte_valid(bv), .frame_err(fe)
  );

  ld_state_t         st_q, st_d;
  logic [7:0]        sum_q, sum_d, lo_q, lo_d;
  logic [15:0]       n_q, n_d, n_rx;
  logic [ADDR_W:0]   words_q, words_d, words_inc;
  logic [TW-1:0]     idle_q, idle_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [15:0]       din_q, din_d;
  logic              w_en_q, w_en_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              in_frame;

  assign n_rx      = {rd, n_q[7:0]};
  assign words_inc = words_q + 1'b1;
  assign in_frame  = st_q inside {S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CHECK};

  always_comb begin
    st_d     = st_q;
    sum_d    = sum_q;
    lo_d     = lo_q;
    n_d      = n_q;
    words_d  = words_q;
    w_addr_d = w_addr_q;
    din_d    = din_q;
    w_en_d   = 1'b0;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    idle_d   = (bv || !in_frame) ? '0 : idle_q + 1'b1;
    if (w_en_q && w_addr_q != '1) w_addr_d = w_addr_q + 1'b1;
    case (st_q)
      S_WAIT_SYNC, S_DONE, S_ERR:
        if (bv && rd == SYNC_BYTE) begin
          st_d    = S_CNT_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          sum_d   = '0;
          words_d = '0;
        end
      S_CNT_LO:
        if (bv) begin
          n_d[7:0] = rd;
          sum_d    = sum_q + rd;
          st_d     = S_CNT_HI;
        end
      S_CNT_HI:
        if (bv) begin
          n_d   = n_rx;
          sum_d = sum_q + rd;
          if (n_rx == 16'd0) st_d = S_CHECK;
          else if (17'(n_rx) > MAX_WORDS) st_d = S_ERR;
          else begin
            w_addr_d = '0;
            st_d     = S_DATA_LO;
          end
        end
      S_DATA_LO:
        if (bv) begin
          lo_d  = rd;
          sum_d = sum_q + rd;
          st_d  = S_DATA_HI;
        end
      S_DATA_HI:
        if (bv) begin
          din_d   = {rd, lo_q};
          w_en_d  = 1'b1;
          sum_d   = sum_q + rd;
          words_d = words_inc;
          st_d    = (17'(words_inc) == {1'b0, n_q}) ? S_CHECK : S_DATA_LO;
        end
      S_CHECK:
        if (bv) st_d = (rd == sum_q) ? S_DONE : S_ERR;
      default: st_d = S_WAIT_SYNC;
    endcase
    // Line faults and stalls abort the frame; words already written are left in place.
    if (in_frame && (fe || (!bv && idle_q == TW'(TIMEOUT_CYC + 1)))) st_d = S_ERR;
    if (st_d == S_DONE) begin
      hold_d = 1'b0;
      done_d = 1'b1;
    end
    if (st_d == S_ERR) begin
      hold_d = 1'b1;
      err_d  = 1'b1;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_WAIT_SYNC;
      sum_q    <= '0;
      lo_q     <= '0;
      n_q      <= '0;
      words_q  <= '0;
      idle_q   <= '0;
      w_addr_q <= '0;
      din_q    <= '0;
      w_en_q   <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      sum_q    <= sum_d;
      lo_q     <= lo_d;
      n_q      <= n_d;
      words_q  <= words_d;
      idle_q   <= idle_d;
      w_addr_q <= w_addr_d;
      din_q    <= din_d;
      w_en_q   <= w_en_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign w_addr   = w_addr_q;
  assign din      = din_q;
  assign w_en     = w_en_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: framed images driven over rx at 16 clk/bit.
module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [11:0] w_addr;
  logic [15:0] din;
  logic        w_en, cpu_hold, done, error;

  int checks = 0;
  int errors = 0;

  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];

  imem_uart_loader #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .ADDR_W(12), .TIMEOUT_CYC(65535)) dut (
    .clk(clk), .rst(rst), .rx(rx), .w_addr(w_addr), .din(din), .w_en(w_en),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wa_q.push_back(w_addr);
      wd_q.push_back(din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    if (bad_stop) repeat (16) @(negedge clk);
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic send_good_frame();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'hC0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_din", din, 0);

    // 1: good two-word image
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    chk("s1_hold_loading", cpu_hold, 1);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'hC0);
    repeat (20) @(negedge clk);
    chk("s1_nwrites", wa_q.size(), 2);
    chk("s1_addr0", wa_q[0], 12'h000);
    chk("s1_data0", wd_q[0], 16'h1234);
    chk("s1_addr1", wa_q[1], 12'h001);
    chk("s1_data1", wd_q[1], 16'hABCD);
    chk("s1_done", done, 1);
    chk("s1_hold", cpu_hold, 0);
    chk("s1_error", error, 0);

    // 2: bad checksum
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'hC1);
    repeat (20) @(negedge clk);
    chk("s2_nwrites", wa_q.size(), 2);
    chk("s2_error", error, 1);
    chk("s2_hold", cpu_hold, 1);
    chk("s2_done", done, 0);

    // 3: junk before sync, empty image
    clear_writes();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (20) @(negedge clk);
    chk("s3_nwrites", wa_q.size(), 0);
    chk("s3_done", done, 1);
    chk("s3_error", error, 0);
    chk("s3_hold", cpu_hold, 0);

    // 4: oversize count, then recovery
    clear_writes();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    repeat (20) @(negedge clk);
    chk("s4_error", error, 1);
    chk("s4_done", done, 0);
    chk("s4_nwrites", wa_q.size(), 0);
    send_good_frame();
    chk("s4_rec_error", error, 0);
    chk("s4_rec_done", done, 1);
    chk("s4_rec_nwrites", wa_q.size(), 2);

    // 5: inter-byte timeout, then bad stop bit
    clear_writes();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34);
    repeat (65000) @(negedge clk);
    chk("s5_no_early_timeout", error, 0);
    for (int i = 0; i < 2000 && error !== 1'b1; i++) @(negedge clk);
    chk("s5_timeout_error", error, 1);
    chk("s5_timeout_hold", cpu_hold, 1);
    chk("s5_timeout_nwrites", wa_q.size(), 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    chk("s5_restart_clears", error, 0);
    send_byte(8'h34, 1'b1);
    repeat (20) @(negedge clk);
    chk("s5_framing_error", error, 1);
    chk("s5_framing_nwrites", wa_q.size(), 0);

    // 6: resync after done, then reset mid-data
    send_good_frame();
    chk("s6_done", done, 1);
    clear_writes();
    send_byte(8'hA5);
    repeat (4) @(negedge clk);
    chk("s6_hold_rises", cpu_hold, 1);
    chk("s6_done_drops", done, 0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s6_rst_hold", cpu_hold, 1);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_error", error, 0);
    chk("s6_rst_wen", w_en, 0);
    chk("s6_rst_waddr", w_addr, 0);
    chk("s6_rst_din", din, 0);
    send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'hC0);
    repeat (20) @(negedge clk);
    chk("s6_no_writes", wa_q.size(), 0);
    chk("s6_still_held", cpu_hold, 1);
    chk("s6_not_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
